sequence_detector_param: RTL and testbench

//  Parametrised serial pattern detector, successor of the fixed 1011 Mealy detector.

---
 rtl/sequence_detector_param_pkg.sv | 18 +
 rtl/sequence_detector_param_match_window.sv | 58 +++++
 rtl/sequence_detector_param.sv | 86 ++++++++
 tb/tb_sequence_detector_param.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_detector_param_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
// Output mode encoding, default pattern/length and the length-field width helper.
package sequence_detector_param_pkg;

   typedef enum logic {
      MODE_MOORE = 1'b0,
      MODE_MEALY = 1'b1
   } mode_e;

   localparam int unsigned DEF_MAX_LEN = 8;
   localparam logic [7:0]  DEF_PATTERN = 8'b0000_1011;
   localparam int unsigned DEF_LEN     = 4;

   function automatic int unsigned len_w(input int unsigned max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sequence_detector_param_match_window.sv
// Bit history, fill tracking and pattern compare; hit is combinational on the current bit.
// No backpressure: bits are consumed whenever in_valid is high, gap cycles hold state.
module sequence_detector_param_match_window
   import sequence_detector_param_pkg::*;
#(
   parameter int unsigned MAX_LEN = DEF_MAX_LEN,
   parameter int unsigned LW      = len_w(MAX_LEN)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               in_valid,
   input  logic               sequence_in,
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LW-1:0]      len,
   input  logic               overlap,
   output logic               hit
);

   // The oldest history bit would shift straight out of the window, so it is not stored.
   logic [MAX_LEN-2:0] hist;
   logic [MAX_LEN-1:0] win;
   logic [MAX_LEN-1:0] mask;
   logic [LW-1:0]      fill;
   logic [LW:0]        fill_inc;

   assign win      = {hist, sequence_in};
   assign fill_inc = {1'b0, fill} + (LW+1)'(1);

   always_comb begin
      mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         mask[i] = (i < int'(len));
      end
   end

   assign hit = in_valid & ~clear & (len != '0) & (fill_inc >= {1'b0, len})
              & (((win ^ pat) & mask) == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         fill <= '0;
      end else if (clear) begin
         hist <= '0;
         fill <= '0;
      end else if (in_valid) begin
         hist <= win[MAX_LEN-2:0];
         if (hit && !overlap)
            fill <= '0;
         else if (fill_inc > (LW+1)'(MAX_LEN))
            fill <= LW'(MAX_LEN);
         else
            fill <= fill_inc[LW-1:0];
      end
   end

endmodule

// File: rtl/sequence_detector_param.sv
// Runtime-configurable serial pattern detector with saturating match counter.
// Mealy output 0-cycle, Moore output 1-cycle latency; in_valid gaps hold state, no backpressure.
module sequence_detector_param
   import sequence_detector_param_pkg::*;
#(
   parameter int unsigned        MAX_LEN         = DEF_MAX_LEN,
   parameter int unsigned        CNT_W           = 16,
   parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
   parameter int unsigned        DEFAULT_LEN     = DEF_LEN,
   localparam int unsigned       LW              = len_w(MAX_LEN)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sequence_in,
   input  logic               in_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               cfg_mealy,
   output logic               detector_out,
   output logic [CNT_W-1:0]   match_count,
   output logic               count_sat
);

   logic [MAX_LEN-1:0] pat_q;
   logic [LW-1:0]      len_q;
   logic               overlap_q;
   mode_e              mode_q;
   logic               moore_q;
   logic               hit;
   logic [CNT_W-1:0]   count_nxt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pat_q     <= DEFAULT_PATTERN;
         len_q     <= LW'(DEFAULT_LEN);
         overlap_q <= 1'b1;
         mode_q    <= MODE_MEALY;
      end else if (cfg_load) begin
         pat_q     <= cfg_pattern;
         len_q     <= (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
         overlap_q <= cfg_overlap;
         mode_q    <= mode_e'(cfg_mealy);
      end
   end

   sequence_detector_param_match_window #(
      .MAX_LEN (MAX_LEN),
      .LW      (LW)
   ) u_window (
      .clock       (clock),
      .reset       (reset),
      .clear       (cfg_load),
      .in_valid    (in_valid),
      .sequence_in (sequence_in),
      .pat         (pat_q),
      .len         (len_q),
      .overlap     (overlap_q),
      .hit         (hit)
   );

   assign count_nxt = match_count + CNT_W'(1);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         moore_q     <= 1'b0;
         match_count <= '0;
         count_sat   <= 1'b0;
      end else if (cfg_load) begin
         moore_q     <= 1'b0;
         match_count <= '0;
         count_sat   <= 1'b0;
      end else begin
         moore_q <= hit;
         if (hit && !(&match_count)) begin
            match_count <= count_nxt;
            if (&count_nxt)
               count_sat <= 1'b1;
         end
      end
   end

   assign detector_out = (mode_q == MODE_MEALY) ? hit : moore_q;

endmodule

// File: tb/tb_sequence_detector_param.sv
// Bench for sequence_detector_param: directed streams plus a queue-based reference model
// checked every cycle on a default instance and a 3-bit-counter instance.
module tb_sequence_detector_param;

   logic       clock;
   logic       reset;
   logic       sequence_in;
   logic       in_valid;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       cfg_mealy;
   logic        det;
   logic [15:0] cnt;
   logic        sat;
   logic        det_s;
   logic [2:0]  cnt_s;
   logic        sat_s;

   int errs   = 0;
   int checks = 0;

   sequence_detector_param u_dut (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy),
      .detector_out(det), .match_count(cnt), .count_sat(sat)
   );

   sequence_detector_param #(.CNT_W(3)) u_dut_small (
      .clock(clock), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cfg_mealy(cfg_mealy),
      .detector_out(det_s), .match_count(cnt_s), .count_sat(sat_s)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: the valid bits seen since the last clear, newest at the back.
   bit       mq[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ov, m_me, m_moore, m_sat, m_sat3;
   int       m_cnt, m_cnt3;

   function automatic void model_reset();
      mq.delete();
      m_pat = 8'b0000_1011; m_len = 4; m_ov = 1'b1; m_me = 1'b1;
      m_moore = 1'b0; m_cnt = 0; m_cnt3 = 0; m_sat = 1'b0; m_sat3 = 1'b0;
   endfunction

   function automatic bit model_hit();
      bit b;
      if (!in_valid || cfg_load || m_len == 0 || mq.size() + 1 < m_len) return 1'b0;
      for (int k = 0; k < m_len; k++) begin
         b = (k == 0) ? sequence_in : mq[mq.size() - k];
         if (b != m_pat[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_edge();
      bit h;
      if (cfg_load) begin
         model_reset();
         m_pat = cfg_pattern;
         m_len = (cfg_len > 8) ? 8 : int'(cfg_len);
         m_ov  = cfg_overlap;
         m_me  = cfg_mealy;
         return;
      end
      h = model_hit();
      m_moore = h;
      if (in_valid) begin
         if (h && !m_ov) mq.delete();
         else begin
            mq.push_back(sequence_in);
            if (mq.size() > 8) void'(mq.pop_front());
         end
      end
      if (h) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt == 65535) m_sat = 1'b1;
         if (m_cnt3 < 7) m_cnt3++;
         if (m_cnt3 == 7) m_sat3 = 1'b1;
      end
   endfunction

   initial begin : compare
      bit eh, eo;
      model_reset();
      forever begin
         @(negedge clock);
         #2;
         if (!reset) model_reset();
         eh = model_hit();
         eo = m_me ? eh : m_moore;
         chk("model_det",      32'(det),    32'(eo));
         chk("model_cnt",      32'(cnt),    32'(m_cnt));
         chk("model_sat",      32'(sat),    32'(m_sat));
         chk("model_det_s",    32'(det_s),  32'(eo));
         chk("model_cnt_s",    32'(cnt_s),  32'(m_cnt3));
         chk("model_sat_s",    32'(sat_s),  32'(m_sat3));
         @(posedge clock);
         if (reset) model_edge();
      end
   end

   task automatic send(input logic b);
      @(negedge clock);
      cfg_load = 1'b0; in_valid = 1'b1; sequence_in = b;
   endtask

   task automatic idle();
      @(negedge clock);
      cfg_load = 1'b0; in_valid = 1'b0; sequence_in = 1'b0;
   endtask

   task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic me,
                       input logic v, input logic b);
      @(negedge clock);
      cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_mealy = me;
      in_valid = v; sequence_in = b;
   endtask

   // bits[0] is sent first; hits[i] records detector_out during bit i.
   task automatic run_stream(input logic [15:0] bits, input int n, input bit gaps,
                             output logic [15:0] hits, output logic [15:0] gap_hits);
      hits = '0; gap_hits = '0;
      for (int i = 0; i < n; i++) begin
         send(bits[i]);
         #1 hits[i] = det;
         if (gaps) begin
            idle();
            #1 gap_hits[i] = det;
         end
      end
   endtask

   initial begin : drive
      logic [15:0] h, g, bits;
      logic [7:0]  p;
      reset = 1'b0; in_valid = 1'b0; sequence_in = 1'b0; cfg_load = 1'b0;
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_mealy = 1'b0;
      #1;
      chk("reset_det", 32'(det), 32'd0);
      chk("reset_cnt", 32'(cnt), 32'd0);
      chk("reset_sat", 32'(sat), 32'd0);
      @(negedge clock);
      reset = 1'b1;

      // T1: defaults detect 1011 on the 4th bit
      run_stream(16'h000D, 4, 1'b0, h, g);
      chk("t1_hits", 32'(h), 32'h0008);
      idle();
      #1 chk("t1_cnt", 32'(cnt), 32'd1);

      // T2: overlapping then non-overlapping on 1,0,1,1,0,1,1
      load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(16'h006D, 7, 1'b0, h, g);
      chk("t2_ov_hits", 32'(h), 32'h0048);
      idle();
      #1 chk("t2_ov_cnt", 32'(cnt), 32'd2);
      load(8'b0000_1011, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      run_stream(16'h006D, 7, 1'b0, h, g);
      chk("t2_nov_hits", 32'(h), 32'h0008);
      idle();
      #1 chk("t2_nov_cnt", 32'(cnt), 32'd1);

      // T3: Moore output one cycle late, single cycle wide
      load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
      run_stream(16'h000D, 4, 1'b0, h, g);
      chk("t3_mealy_cycle", 32'(h), 32'h0000);
      idle();
      #1 chk("t3_next_cycle", 32'(det), 32'd1);
      idle();
      #1 chk("t3_after", 32'(det), 32'd0);

      // T4: 8-bit pattern with idle gaps, then a corrupted copy
      p = 8'b1110_0101;
      bits = '0;
      for (int i = 0; i < 8; i++) bits[i] = p[7-i];
      load(p, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(bits, 8, 1'b1, h, g);
      chk("t4_hits", 32'(h), 32'h0080);
      chk("t4_gaps", 32'(g), 32'h0000);
      #1 chk("t4_cnt", 32'(cnt), 32'd1);
      load(p, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(bits ^ 16'h0008, 8, 1'b1, h, g);
      chk("t4_bad_hits", 32'(h), 32'h0000);
      #1 chk("t4_bad_cnt", 32'(cnt), 32'd0);

      // T5: saturation of the 3-bit counter
      load(8'h01, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         send(1'b1);
         #1;
         if (i == 6) begin
            chk("t5_cnt6", 32'(cnt_s), 32'd6);
            chk("t5_sat6", 32'(sat_s), 32'd0);
         end
         if (i == 7) begin
            chk("t5_cnt7", 32'(cnt_s), 32'd7);
            chk("t5_sat7", 32'(sat_s), 32'd1);
         end
      end
      idle();
      #1;
      chk("t5_cnt_hold", 32'(cnt_s), 32'd7);
      chk("t5_sat_hold", 32'(sat_s), 32'd1);
      chk("t5_cnt_wide", 32'(cnt),   32'd9);
      load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      idle();
      #1;
      chk("t5_clr_cnt", 32'(cnt_s), 32'd0);
      chk("t5_clr_sat", 32'(sat_s), 32'd0);

      // T6: asynchronous reset mid-stream restores defaults and drops history
      load(8'b0000_0101, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(16'h0005, 3, 1'b0, h, g);
      chk("t6_pre_hits", 32'(h), 32'h0004);
      @(posedge clock);
      #1 chk("t6_pre_cnt", 32'(cnt), 32'd1);
      #1;
      reset = 1'b0; in_valid = 1'b0;
      #1;
      chk("t6_rst_det", 32'(det), 32'd0);
      chk("t6_rst_cnt", 32'(cnt), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      run_stream(16'h000D, 4, 1'b0, h, g);
      chk("t6_post_hits", 32'(h), 32'h0008);

      // T7: load discards a same-edge sample; len 0 disables; len 12 clamps to 8
      load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(16'h0005, 3, 1'b0, h, g);
      load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1);
      #1 chk("t7_load_det", 32'(det), 32'd0);
      run_stream(16'h0006, 3, 1'b0, h, g);
      chk("t7_discard_hits", 32'(h), 32'h0000);
      load(8'h00, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(16'h00F0, 8, 1'b0, h, g);
      chk("t7_len0_hits", 32'(h), 32'h0000);
      idle();
      #1 chk("t7_len0_cnt", 32'(cnt), 32'd0);
      p = 8'b1010_0110;
      bits = '0;
      for (int i = 0; i < 8; i++) bits[i] = p[7-i];
      load(p, 4'd12, 1'b1, 1'b1, 1'b0, 1'b0);
      run_stream(bits, 8, 1'b0, h, g);
      chk("t7_clamp_hits", 32'(h), 32'h0080);
      idle();
      #1 chk("t7_clamp_cnt", 32'(cnt), 32'd1);

      repeat (2) @(negedge clock);
      #3;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
